lcd_num_writer: RTL and testbench
=================================

# lcd_num_writer

Converts a 16-bit unsigned binary value into a 5-digit decimal ASCII field and writes it, one character at a time, into the character buffer of the HD44780 LCD driver. It then requests a display refresh.
- Sits directly upstream of the LCD driver.
- Its outputs connect one-to-one to the driver's `inData`, `inAddr`, `isWrite` and `isUpdate` inputs.
- Binary-to-BCD conversion is sequential (shift-and-add-3), so the block costs no wide dividers.

## Interface
Parameters:
- `BLANK_ZEROS`, default 1: when 1, leading zeros of digits 0..3 are replaced by space (0x20). Digit 4 (units) is always printed.

Ports (one clock; reset is asynchronous and active-low):
- `clk_4Mhz`  in  1  system clock, 4 MHz; all state on its rising edge
- `nRst`  in  1  asynchronous active-low reset
- `value`  in  16  unsigned number to display; sampled only when a start is accepted
- `base_addr`  in  6  LCD buffer index of the leftmost digit (0-15 = line 1, 16-31 = line 2)
- `start`  in  1  request; accepted on any edge where `start`=1 and the block is in IDLE
- `outData`  out  8  ASCII character; connects to LCD `inData`
- `outAddr`  out  6  buffer index; connects to LCD `inAddr`
- `isWrite`  out  1  write strobe to LCD, one cycle per character
- `isUpdate`  out  1  refresh request to LCD, one-cycle pulse
- `busy`  out  1  high in every non-IDLE state
- `done`  out  1  one-cycle pulse after the update request

## Operation
States: IDLE, CONV, WR_SET, WR_STB, WR_GAP, UPD.
- **IDLE**
  - On an edge with `start`=1: latch `value` into the binary shift register and `base_addr` into the address register.
  - Clear the 20-bit BCD register and set iteration count = 0.
  - Go to CONV.
- **CONV**, 16 cycles. Each cycle:
  - Every BCD nibble >= 5 gets +3.
  - Then `{bcd, bin}` shifts left by 1.
  - After iteration 15, go to WR_SET with digit index = 0.
- **WR_SET**
  - `outData` = ASCII of digit[idx], where digit 0 is the ten-thousands digit: 0x30 + nibble, or 0x20 if blanked.
  - `outAddr` = (latched base + idx) mod 64.
  - `isWrite` = 0. Go to WR_STB.
- **WR_STB**: `isWrite` = 1; `outData` and `outAddr` are held. Go to WR_GAP.
- **WR_GAP**: `isWrite` = 0; data and address are held.
  - If idx == 4, go to UPD.
  - Otherwise idx+1 and go to WR_SET.
- **UPD**: `isUpdate` = 1 for this cycle. Go to IDLE; `done` = 1 in the first IDLE cycle.
- **Blanking**, when `BLANK_ZEROS`=1:
  - Digit k (k ≤ 3) is blanked iff digits 0..k are all zero.
  - Value 0 is therefore shown as four spaces followed by "0".
- **Address wrap**
  - base+idx is computed modulo 64 with no clamping.
  - Indices above 31 are emitted anyway; the downstream driver ignores them.
  - A field crossing index 15→16 continues on line 2.
- **Ignored / frozen inputs**
  - `start` is ignored while `busy`=1, with no queueing.
  - Changes to `value` or `base_addr` after acceptance have no effect.
- **Reset**
  - Asserting `nRst` in any state immediately forces IDLE and all outputs to their reset values.
  - A partial field may remain in the LCD buffer. No `isUpdate` is issued for an aborted run.

## Timing
- Reset values: `outData`=0x20, `outAddr`=0, `isWrite`=0, `isUpdate`=0, `busy`=0, `done`=0.
- Start is sampled at edge T. Then:
  - `busy` rises after edge T.
  - CONV occupies cycles T+1..T+16.
  - Writes occupy T+17..T+31, 3 cycles per character.
  - The `isWrite` pulses are high in cycles T+18, T+21, T+24, T+27 and T+30.
  - UPD (`isUpdate`=1) is cycle T+32.
  - `busy` falls and `done`=1 in cycle T+33.
- `outData`/`outAddr` are stable from one cycle before `isWrite` rises until one cycle after it falls. This satisfies the driver's level-sensitive buffer write.
- `isWrite` is never high on two consecutive cycles, and `isWrite` and `isUpdate` are never high together.
- A start accepted in the `done` cycle is legal: the next run's CONV begins the following cycle.

## Test plan
- `value`=12345, `base_addr`=0: writes 0x31,0x32,0x33,0x34,0x35 to addresses 0..4 on T+18..T+30 step 3. One `isUpdate` at T+32; `done` at T+33.
- `value`=42, `base_addr`=16, `BLANK_ZEROS`=1: writes 0x20,0x20,0x20,0x34,0x32 to addresses 16..20.
- `value`=0 with `BLANK_ZEROS`=1 gives "    0" (four 0x20 then 0x30). Rerun with `BLANK_ZEROS`=0 gives 0x30 ×5.
- `value`=65535, `base_addr`=62: gives "65535" at addresses 62,63,0,1,2 (wrap mod 64).
- `start` pulsed again at T+10 with `value`=1: ignored. The output is still the first value and there is exactly one `done`.
- `nRst` asserted at T+22: outputs return to reset values immediately. No further `isWrite`, no `isUpdate`, no `done`. A new start after release completes normally.

Source files
------------

// File: rtl/lcd_num_writer.sv
// Renders a 16-bit unsigned value as a 5-character decimal field in the HD44780
// character buffer, one strobed write per character, then requests a refresh.
module lcd_num_writer #(
  parameter int BLANK_ZEROS = 1
) (
  input  logic        clk_4Mhz,
  input  logic        nRst,
  input  logic [15:0] value,
  input  logic [5:0]  base_addr,
  input  logic        start,
  output logic [7:0]  outData,
  output logic [5:0]  outAddr,
  output logic        isWrite,
  output logic        isUpdate,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, CONV, WR_SET, WR_STB, WR_GAP, UPD} state_t;

  state_t      state;
  logic [3:0]  iter;
  logic [2:0]  idx;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic [5:0]  base;
  logic [15:0] bcd_adj;
  logic [19:0] bcd_next;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Digit k of the field as ASCII; digit 0 is the ten-thousands place.
  function automatic logic [7:0] digit_char(input logic [19:0] b, input logic [2:0] k);
    logic [3:0] nib;
    logic       blank;
    case (k)
      3'd0:    begin nib = b[19:16]; blank = (b[19:16] == 4'd0); end
      3'd1:    begin nib = b[15:12]; blank = (b[19:12] == 8'd0); end
      3'd2:    begin nib = b[11:8];  blank = (b[19:8]  == 12'd0); end
      3'd3:    begin nib = b[7:4];   blank = (b[19:4]  == 16'd0); end
      default: begin nib = b[3:0];   blank = 1'b0; end
    endcase
    if ((BLANK_ZEROS != 0) && blank) return 8'h20;
    return {4'h3, nib};
  endfunction

  // The top nibble never exceeds 3 before a shift for a 16-bit input, so it skips the +3 step.
  always_comb begin
    bcd_adj = 16'd0;
    for (int i = 0; i < 4; i++) bcd_adj[4*i +: 4] = add3(bcd[4*i +: 4]);
    bcd_next = {bcd[18:16], bcd_adj, bin[15]};
  end

  always_ff @(posedge clk_4Mhz) begin
    if (state == IDLE && start) begin
      bin  <= value;
      bcd  <= 20'd0;
      base <= base_addr;
    end else if (state == CONV) begin
      bin <= {bin[14:0], 1'b0};
      bcd <= bcd_next;
    end
  end

  always_ff @(posedge clk_4Mhz or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      iter     <= 4'd0;
      idx      <= 3'd0;
      outData  <= 8'h20;
      outAddr  <= 6'd0;
      isWrite  <= 1'b0;
      isUpdate <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      isWrite  <= 1'b0;
      isUpdate <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= CONV;
          iter  <= 4'd0;
          busy  <= 1'b1;
        end
        CONV: begin
          iter <= iter + 4'd1;
          if (iter == 4'd15) begin
            state   <= WR_SET;
            idx     <= 3'd0;
            outData <= digit_char(bcd_next, 3'd0);
            outAddr <= base;
          end
        end
        WR_SET: begin
          state   <= WR_STB;
          isWrite <= 1'b1;
        end
        WR_STB: state <= WR_GAP;
        WR_GAP: begin
          if (idx == 3'd4) begin
            state    <= UPD;
            isUpdate <= 1'b1;
          end else begin
            state   <= WR_SET;
            idx     <= idx + 3'd1;
            outData <= digit_char(bcd, idx + 3'd1);
            outAddr <= base + {3'b000, idx + 3'd1};
          end
        end
        UPD: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_num_writer.sv
// Bench for lcd_num_writer: one instance with zero blanking, one without; writes
// are scoreboarded against a divide/modulo decimal model with per-cycle timing checks.
`timescale 1ns/1ps
module tb_lcd_num_writer;

  logic        clk = 1'b0;
  logic        nRst;
  logic [15:0] value;
  logic [5:0]  base_addr;
  logic        start_b, start_n;
  logic [7:0]  data_b, data_n;
  logic [5:0]  addr_b, addr_n;
  logic        wr_b, wr_n, upd_b, upd_n, busy_b, busy_n, done_b, done_n;

  int checks = 0;
  int failures = 0;
  logic [13:0] q_b[$];
  logic [13:0] q_n[$];
  logic [13:0] e_b, e_n;
  logic        prev_wr_b = 1'b0;
  logic        prev_wr_n = 1'b0;

  always #125 clk = ~clk;

  lcd_num_writer #(.BLANK_ZEROS(1)) dut (
    .clk_4Mhz(clk), .nRst(nRst), .value(value), .base_addr(base_addr), .start(start_b),
    .outData(data_b), .outAddr(addr_b), .isWrite(wr_b), .isUpdate(upd_b),
    .busy(busy_b), .done(done_b)
  );

  lcd_num_writer #(.BLANK_ZEROS(0)) dut_nb (
    .clk_4Mhz(clk), .nRst(nRst), .value(value), .base_addr(base_addr), .start(start_n),
    .outData(data_n), .outAddr(addr_n), .isWrite(wr_n), .isUpdate(upd_n),
    .busy(busy_n), .done(done_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every write strobe pops the next expected {addr, data}
  always @(negedge clk) begin
    if (nRst) begin
      if (wr_b) begin
        chk("consec_wr_b", prev_wr_b, 0);
        if (q_b.size() == 0) chk("unexpected_wr_b", 1, 0);
        else begin
          e_b = q_b.pop_front();
          chk("wr_data_b", data_b, e_b[7:0]);
          chk("wr_addr_b", addr_b, e_b[13:8]);
        end
      end
      if (wr_n) begin
        chk("consec_wr_n", prev_wr_n, 0);
        if (q_n.size() == 0) chk("unexpected_wr_n", 1, 0);
        else begin
          e_n = q_n.pop_front();
          chk("wr_data_n", data_n, e_n[7:0]);
          chk("wr_addr_n", addr_n, e_n[13:8]);
        end
      end
      if (wr_b || upd_b) chk("wr_upd_excl_b", wr_b && upd_b, 0);
      if (wr_n || upd_n) chk("wr_upd_excl_n", wr_n && upd_n, 0);
    end
    prev_wr_b = wr_b;
    prev_wr_n = wr_n;
  end

  task automatic chk_reset(input int sel);
    chk("rst_data",   sel == 0 ? data_b : data_n, 8'h20);
    chk("rst_addr",   sel == 0 ? addr_b : addr_n, 0);
    chk("rst_write",  sel == 0 ? wr_b   : wr_n,   0);
    chk("rst_update", sel == 0 ? upd_b  : upd_n,  0);
    chk("rst_busy",   sel == 0 ? busy_b : busy_n, 0);
    chk("rst_done",   sel == 0 ? done_b : done_n, 0);
  endtask

  task automatic idle_check(input int n, input int sel);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_write",  sel == 0 ? wr_b   : wr_n,   0);
      chk("idle_update", sel == 0 ? upd_b  : upd_n,  0);
      chk("idle_done",   sel == 0 ? done_b : done_n, 0);
      chk("idle_busy",   sel == 0 ? busy_b : busy_n, 0);
    end
  endtask

  // sel 0 drives the blanking instance, sel 1 the non-blanking one.
  task automatic run(input int sel, input logic [15:0] v, input logic [5:0] b,
                     input int abort_at, input int poke_at);
    logic [7:0] ed[5];
    logic [5:0] ea[5];
    logic       lead;
    int         d, dv;
    lead = 1'b1;
    dv = 10000;
    for (int j = 0; j < 5; j++) begin
      d = (int'(v) / dv) % 10;
      dv = dv / 10;
      lead = lead && (d == 0);
      ed[j] = (sel == 0 && j < 4 && lead) ? 8'h20 : 8'(48 + d);
      ea[j] = 6'(int'(b) + j);
      if (sel == 0) q_b.push_back({ea[j], ed[j]});
      else q_n.push_back({ea[j], ed[j]});
    end
    value = v;
    base_addr = b;
    if (sel == 0) start_b = 1'b1; else start_n = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    start_n = 1'b0;
    value = 16'($urandom);
    base_addr = 6'($urandom);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      chk("write_timing",  sel == 0 ? wr_b   : wr_n,   (k >= 18 && k <= 30 && (k - 18) % 3 == 0));
      chk("update_timing", sel == 0 ? upd_b  : upd_n,  k == 32);
      chk("done_timing",   sel == 0 ? done_b : done_n, k == 33);
      chk("busy_timing",   sel == 0 ? busy_b : busy_n, k != 33);
      if (k >= 17 && k <= 31) begin
        chk("data_hold", sel == 0 ? data_b : data_n, ed[(k - 17) / 3]);
        chk("addr_hold", sel == 0 ? addr_b : addr_n, ea[(k - 17) / 3]);
      end
      if (k == poke_at) begin
        value = 16'd1;
        if (sel == 0) start_b = 1'b1; else start_n = 1'b1;
      end
      if (k == poke_at + 1) begin
        start_b = 1'b0;
        start_n = 1'b0;
      end
      if (k == abort_at) begin
        nRst = 1'b0;
        #1;
        chk_reset(sel);
        if (sel == 0) q_b.delete(); else q_n.delete();
        return;
      end
    end
    chk("queue_drained", sel == 0 ? q_b.size() : q_n.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    nRst = 1'b0;
    start_b = 1'b0;
    start_n = 1'b0;
    value = 16'd0;
    base_addr = 6'd0;
    #300;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    nRst = 1'b1;
    idle_check(2, 0);

    run(0, 16'd12345, 6'd0, 0, 0);
    run(0, 16'd42, 6'd16, 0, 0);      // accepted in the previous run's done cycle
    idle_check(3, 0);
    run(0, 16'd0, 6'd5, 0, 0);
    run(1, 16'd0, 6'd5, 0, 0);
    run(1, 16'd42, 6'd0, 0, 0);
    idle_check(2, 1);
    run(0, 16'd65535, 6'd62, 0, 0);
    run(0, 16'd12345, 6'd3, 0, 10);   // second start during CONV must be ignored
    idle_check(8, 0);

    run(0, 16'd9876, 6'd10, 22, 0);
    @(negedge clk);
    @(negedge clk);
    chk_reset(0);
    nRst = 1'b1;
    idle_check(4, 0);
    run(0, 16'd907, 6'd14, 0, 0);
    idle_check(3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
